uart_rx_deserializer: RTL

Receive-side serial front end of the UART. It synchronises the `RXD` line, oversamples it at 16× using the baud generator's tick, and assembles start/data/parity/stop bits into one character plus error status. The result is offered through a valid/ready handshake to the RX FIFO / APB register stage downstream. Line-control settings come from the LCR register fields.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_rx_deserializer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e     : receive FSM states
//   WLS_*          : LCR word-length-select encodings
//   OVERSAMPLE     : baud ticks per bit
//   MID_SAMPLE     : tick index (after start-edge detection) of the start-bit sample
//   last_bit_idx() : index of the final data bit for a given word length
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
        case (wls)
            WLS_5:   return 3'd4;
            WLS_6:   return 3'd5;
            WLS_7:   return 3'd6;
            WLS_8:   return 3'd7;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input plus falling-edge detect.
//   clk_i, rst_ni : clock, async active-low reset (all flops reset to 1 = idle line)
//   d_i           : asynchronous input
//   en_i          : update enable for the edge-history flop (tie high for per-clock edges)
//   q_o           : synchronised level
//   fall_o        : synchronised level went 1 -> 0 since the last enabled cycle
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    input  logic en_i,
    output logic q_o,
    output logic fall_o
);

    logic s1_q, s2_q, prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            // History only advances when enabled, so an edge stays visible
            // until the next enabled cycle instead of being a one-clock pulse.
            if (en_i) prev_q <= s2_q;
        end
    end

    assign q_o    = s2_q;
    assign fall_o = prev_q & ~s2_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 16x oversampled start/data/parity/stop framing.
//   clock, PRESETn         : clock, async active-low reset
//   baud_tick              : one-cycle enable at 16x baud; all framing state advances on it
//   RXD                    : asynchronous serial input, idle high
//   lcr_wls/pen/eps/sp     : character format, captured at each valid start bit
//   rx_data, rx_pe/fe/bi   : received character and status, qualified by rx_valid
//   rx_valid, rx_ready     : output handshake
//   rx_overrun             : one-cycle pulse when a completed character is dropped
//   rx_busy                : receiver is inside a frame
module uart_rx_deserializer
    import uart_pkg::*;
(
    input  logic       clock,
    input  logic       PRESETn,
    input  logic       baud_tick,
    input  logic       RXD,
    input  logic [1:0] lcr_wls,
    input  logic       lcr_pen,
    input  logic       lcr_eps,
    input  logic       lcr_sp,
    output logic [7:0] rx_data,
    output logic       rx_pe,
    output logic       rx_fe,
    output logic       rx_bi,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       rx_busy
);

    logic       rxd_s, rxd_fall;
    rx_state_e  state_q;
    logic [3:0] tick_cnt_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [1:0] wls_q;
    logic       pen_q, eps_q, sp_q, par_q;

    uart_rx_sync u_sync (
        .clk_i (clock),
        .rst_ni(PRESETn),
        .d_i   (RXD),
        .en_i  (baud_tick),
        .q_o   (rxd_s),
        .fall_o(rxd_fall)
    );

    // The counter is cleared on the edge-detect tick, so value k-1 marks the
    // k-th tick after it; bits after the start are sampled every 16 ticks.
    logic tick_mid, tick_end, done;
    assign tick_mid = (tick_cnt_q == 4'(MID_SAMPLE - 1));
    assign tick_end = (tick_cnt_q == 4'(OVERSAMPLE - 1));
    assign done     = baud_tick && (state_q == STOP) && tick_end;

    // Bits enter at the MSB, so an N-bit word ends up in the top N bits.
    logic [1:0] sh_amt_d;
    logic [7:0] data_d;
    logic       par_exp_d, pe_d, fe_d, bi_d;
    assign sh_amt_d  = 2'd3 - wls_q;
    assign data_d    = shift_q >> sh_amt_d;
    assign par_exp_d = sp_q ? ~eps_q : ((^shift_q) ^ ~eps_q);
    assign pe_d      = pen_q & (par_q ^ par_exp_d);
    assign fe_d      = ~rxd_s;
    assign bi_d      = (shift_q == 8'h00) & ~(pen_q & par_q) & ~rxd_s;

    assign rx_busy = (state_q != IDLE);

    always_ff @(posedge clock or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            wls_q      <= '0;
            pen_q      <= 1'b0;
            eps_q      <= 1'b0;
            sp_q       <= 1'b0;
            par_q      <= 1'b0;
            rx_data    <= '0;
            rx_pe      <= 1'b0;
            rx_fe      <= 1'b0;
            rx_bi      <= 1'b0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (baud_tick) begin
                case (state_q)
                    IDLE: begin
                        if (rxd_fall) begin
                            state_q    <= START;
                            tick_cnt_q <= '0;
                        end
                    end
                    START: begin
                        if (tick_mid) begin
                            tick_cnt_q <= '0;
                            if (rxd_s) begin
                                state_q <= IDLE;      // glitch, not a start bit
                            end else begin
                                wls_q     <= lcr_wls;
                                pen_q     <= lcr_pen;
                                eps_q     <= lcr_eps;
                                sp_q      <= lcr_sp;
                                shift_q   <= '0;
                                bit_cnt_q <= '0;
                                state_q   <= DATA;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                    DATA: begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_end) begin
                            shift_q <= {rxd_s, shift_q[7:1]};
                            if (bit_cnt_q == last_bit_idx(wls_q))
                                state_q <= pen_q ? PARITY : STOP;
                            else
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    PARITY: begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        if (tick_end) begin
                            par_q   <= rxd_s;
                            state_q <= STOP;
                        end
                    end
                    STOP: begin
                        tick_cnt_q <= tick_cnt_q + 4'd1;
                        // A start edge already pending lets frames run back to back.
                        if (tick_end) begin
                            tick_cnt_q <= '0;
                            state_q    <= rxd_fall ? START : IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= data_d;
                    rx_pe    <= pe_d;
                    rx_fe    <= fe_d;
                    rx_bi    <= bi_d;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;       // held character wins
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
